// File: rtl/muxf_tree_pipe.sv
// Pipelined MUXF-style 2:1 mux tree over N_INPUTS x WIDTH inputs, with a register after
// every REG_EVERY levels, valid/select-error tags travelling with the data, and a debug force.
module muxf_tree_pipe #(
    parameter int               N_INPUTS  = 8,
    parameter int               WIDTH     = 1,
    parameter int               REG_EVERY = 2,
    parameter logic [WIDTH-1:0] INIT      = '0,
    localparam int              SW        = (N_INPUTS > 2) ? $clog2(N_INPUTS) : 1
) (
    input  logic                      C,
    input  logic                      R,
    input  logic                      CE,
    input  logic [N_INPUTS*WIDTH-1:0] I,
    input  logic [SW-1:0]             S,
    input  logic                      VI,
    input  logic                      FORCE_EN,
    input  logic [WIDTH-1:0]          FORCE_VAL,
    output logic [WIDTH-1:0]          O,
    output logic                      VO,
    output logic                      SEL_ERR
);
    // N_INPUTS >= 2, so the tree depth always equals the select width.
    localparam int          L     = SW;
    localparam int          P     = (L + REG_EVERY - 1) / REG_EVERY;
    localparam logic [SW:0] N_LIM = N_INPUTS[SW:0];

    for (genvar s = 0; s < P; s++) begin : g_stage
        localparam int LVL0  = s * REG_EVERY;
        localparam int NLVL  = (L - LVL0 < REG_EVERY) ? (L - LVL0) : REG_EVERY;
        localparam int SIN_W = L - LVL0;
        localparam int M_IN  = 1 << SIN_W;
        localparam int M_OUT = M_IN >> NLVL;

        logic [WIDTH-1:0] din    [M_IN];
        logic [WIDTH-1:0] work   [M_IN];
        logic [WIDTH-1:0] data_d [M_OUT];
        logic [WIDTH-1:0] data_q [M_OUT];
        logic [SIN_W-1:0] sin;
        logic             vin;
        logic             ein;
        logic             vld_d;
        logic             vld_q;
        logic             err_d;
        logic             err_q;

        if (s == 0) begin : g_src
            // Leaves beyond N_INPUTS read as zero so out-of-range selects yield 0.
            for (genvar k = 0; k < M_IN; k++) begin : g_leaf
                if (k < N_INPUTS) begin : g_in
                    assign din[k] = I[k*WIDTH +: WIDTH];
                end else begin : g_pad
                    assign din[k] = '0;
                end
            end
            assign sin = S;
            assign vin = VI;
            assign ein = ({1'b0, S} >= N_LIM);
        end else begin : g_chain
            assign din = g_stage[s-1].data_q;
            assign sin = g_stage[s-1].g_fwd.sel_q;
            assign vin = g_stage[s-1].vld_q;
            assign ein = g_stage[s-1].err_q;
        end

        always_comb begin
            for (int k = 0; k < M_IN; k++) begin
                work[k] = din[k];
            end
            // In-place reduction: entry k only reads entries 2k/2k+1, which are not yet overwritten.
            for (int j = 0; j < NLVL; j++) begin
                for (int k = 0; k < (M_IN >> (j + 1)); k++) begin
                    work[k] = sin[j] ? work[2*k+1] : work[2*k];
                end
            end
            for (int k = 0; k < M_OUT; k++) begin
                data_d[k] = work[k];
            end
            vld_d = vin;
            err_d = ein;
        end

        always_ff @(posedge C) begin
            if (R) begin
                for (int k = 0; k < M_OUT; k++) begin
                    data_q[k] <= INIT;
                end
                vld_q <= 1'b0;
                err_q <= 1'b0;
            end else if (CE) begin
                data_q <= data_d;
                vld_q  <= vld_d;
                err_q  <= err_d;
            end
        end

        // Select bits not consumed here ride along to the next stage.
        if (s < P - 1) begin : g_fwd
            logic [SIN_W-NLVL-1:0] sel_d;
            logic [SIN_W-NLVL-1:0] sel_q;

            always_comb begin
                sel_d = sin[SIN_W-1:NLVL];
            end

            always_ff @(posedge C) begin
                if (R) begin
                    sel_q <= '0;
                end else if (CE) begin
                    sel_q <= sel_d;
                end
            end
        end
    end

    always_comb begin
        O = FORCE_EN ? FORCE_VAL : g_stage[P-1].data_q[0];
    end

    assign VO      = g_stage[P-1].vld_q;
    assign SEL_ERR = g_stage[P-1].err_q;

endmodule

// File: tb/tb_muxf_tree_pipe.sv
// Scoreboard bench for muxf_tree_pipe: two configurations (N=8/W=4/RE=2 and N=6/W=8/RE=1)
// driven with directed vectors; a monitor per DUT pops expected results whenever VO is high.
module tb_muxf_tree_pipe;
    localparam int PA = 2;
    localparam int PB = 3;

    typedef struct {
        logic [7:0] o;
        logic       err;
        int         tgt;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DUT A: 8 x 4-bit, register every 2 levels
    logic        r_a, ce_a, vi_a, fe_a;
    logic [31:0] i_a;
    logic [2:0]  s_a;
    logic [3:0]  fv_a, o_a;
    logic        vo_a, err_a;
    int          ce_cnt_a = 0;
    exp_t        q_a[$];
    exp_t        ea;

    // DUT B: 6 x 8-bit, register every level
    logic        r_b, ce_b, vi_b, fe_b;
    logic [47:0] i_b;
    logic [2:0]  s_b;
    logic [7:0]  fv_b, o_b;
    logic        vo_b, err_b;
    int          ce_cnt_b = 0;
    exp_t        q_b[$];
    exp_t        eb;

    muxf_tree_pipe #(.N_INPUTS(8), .WIDTH(4), .REG_EVERY(2), .INIT(4'h5)) u_a (
        .C(clk), .R(r_a), .CE(ce_a), .I(i_a), .S(s_a), .VI(vi_a),
        .FORCE_EN(fe_a), .FORCE_VAL(fv_a), .O(o_a), .VO(vo_a), .SEL_ERR(err_a)
    );

    muxf_tree_pipe #(.N_INPUTS(6), .WIDTH(8), .REG_EVERY(1), .INIT(8'h05)) u_b (
        .C(clk), .R(r_b), .CE(ce_b), .I(i_b), .S(s_b), .VI(vi_b),
        .FORCE_EN(fe_b), .FORCE_VAL(fv_b), .O(o_b), .VO(vo_b), .SEL_ERR(err_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Count of CE-high, non-reset edges: an accepted sample must emerge exactly P of them later.
    always @(posedge clk) begin
        if (ce_a && !r_a) ce_cnt_a <= ce_cnt_a + 1;
        if (ce_b && !r_b) ce_cnt_b <= ce_cnt_b + 1;
    end

    always @(negedge clk) begin
        if (vo_a === 1'b1) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_vo", 64'd1, 64'd0);
            end else begin
                ea = q_a.pop_front();
                check("a_data", {60'd0, o_a}, fe_a ? {60'd0, fv_a} : {60'd0, ea.o[3:0]});
                check("a_sel_err", {63'd0, err_a}, {63'd0, ea.err});
                check("a_latency", 64'(ce_cnt_a), 64'(ea.tgt));
            end
        end
    end

    always @(negedge clk) begin
        if (vo_b === 1'b1) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_vo", 64'd1, 64'd0);
            end else begin
                eb = q_b.pop_front();
                check("b_data", {56'd0, o_b}, fe_b ? {56'd0, fv_b} : {56'd0, eb.o});
                check("b_sel_err", {63'd0, err_b}, {63'd0, eb.err});
                check("b_latency", 64'(ce_cnt_b), 64'(eb.tgt));
            end
        end
    end

    task automatic send_a(input logic [2:0] s, input logic [3:0] exp_o, input logic exp_e);
        exp_t e;
        @(posedge clk); #2;
        s_a = s; vi_a = 1'b1; ce_a = 1'b1;
        e.o = {4'd0, exp_o}; e.err = exp_e; e.tgt = ce_cnt_a + PA;
        q_a.push_back(e);
    endtask

    task automatic send_b(input logic [2:0] s, input logic [7:0] exp_o, input logic exp_e);
        exp_t e;
        @(posedge clk); #2;
        s_b = s; vi_b = 1'b1; ce_b = 1'b1;
        e.o = exp_o; e.err = exp_e; e.tgt = ce_cnt_b + PB;
        q_b.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #2;
            vi_a = 1'b0; vi_b = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 50) begin
            @(posedge clk);
            n++;
        end
        check("drain_q_a", 64'(q_a.size()), 64'd0);
        check("drain_q_b", 64'(q_b.size()), 64'd0);
    endtask

    initial begin
        r_a = 1'b1; ce_a = 1'b1; vi_a = 1'b0; fe_a = 1'b0; fv_a = 4'h0; s_a = 3'd0; i_a = 32'hFEDCBA98;
        r_b = 1'b1; ce_b = 1'b1; vi_b = 1'b0; fe_b = 1'b0; fv_b = 8'h00; s_b = 3'd0; i_b = 48'hA5_55_44_33_22_11;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("a_reset_o", {60'd0, o_a}, 64'h5);
        check("a_reset_vo", {63'd0, vo_a}, 64'd0);
        check("a_reset_err", {63'd0, err_a}, 64'd0);
        check("b_reset_o", {56'd0, o_b}, 64'h05);
        check("b_reset_vo", {63'd0, vo_b}, 64'd0);

        // Reset and force together: forced value shows, tags stay clear
        #1; fe_a = 1'b1; fv_a = 4'h9;
        @(posedge clk); #1;
        check("a_rst_force_o", {60'd0, o_a}, 64'h9);
        check("a_rst_force_vo", {63'd0, vo_a}, 64'd0);
        check("a_rst_force_err", {63'd0, err_a}, 64'd0);
        #1; fe_a = 1'b0; r_a = 1'b0; r_b = 1'b0;
        idle(2);

        // Single sample S=5 on A
        send_a(3'd5, 4'hD, 1'b0);
        idle(4);

        // Back-to-back stream S=0..7 on A
        for (int s = 0; s < 8; s++) send_a(3'(s), 4'(8 + s), 1'b0);
        idle(4);

        // Out-of-range selects on B, then a valid one
        send_b(3'd6, 8'h00, 1'b1);
        send_b(3'd7, 8'h00, 1'b1);
        send_b(3'd5, 8'hA5, 1'b0);
        send_b(3'd0, 8'h11, 1'b0);
        idle(5);

        // Force while streaming on A
        for (int s = 0; s < 8; s++) begin
            send_a(3'(s), 4'(8 + s), 1'b0);
            if (s == 3) begin
                fe_a = 1'b1; fv_a = 4'hC;
                #1;
                check("a_force_now", {60'd0, o_a}, 64'hC);
            end
            if (s == 6) fe_a = 1'b0;
        end
        idle(4);

        // Stall mid-flight on A; changed inputs during CE=0 must be ignored
        i_a = 32'h76543210; s_a = 3'd3;
        idle(3);
        send_a(3'd3, 4'h3, 1'b0);
        @(posedge clk); #2;
        ce_a = 1'b0; vi_a = 1'b1; s_a = 3'd7; i_a = 32'hFFFFFFFF;
        repeat (4) begin
            @(posedge clk); #1;
            check("a_stall_vo", {63'd0, vo_a}, 64'd0);
            check("a_stall_o", {60'd0, o_a}, 64'h3);
        end
        #1; ce_a = 1'b1; vi_a = 1'b0; s_a = 3'd0;
        idle(4);

        // Reset with CE=0 while two samples are in flight on B
        send_b(3'd1, 8'h22, 1'b0);
        send_b(3'd2, 8'h33, 1'b0);
        @(posedge clk); #2;
        vi_b = 1'b0; r_b = 1'b1; ce_b = 1'b0;
        q_b.delete();
        @(posedge clk); #1;
        check("b_midrst_o", {56'd0, o_b}, 64'h05);
        check("b_midrst_vo", {63'd0, vo_b}, 64'd0);
        check("b_midrst_err", {63'd0, err_b}, 64'd0);
        #1; r_b = 1'b0; ce_b = 1'b1;
        idle(5);
        send_b(3'd3, 8'h44, 1'b0);
        idle(5);

        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
